// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the PHI0 clock controller.
//   state_e    : sequencer phases (low, high, stretched high, halted low)
//   HALF_MIN   : smallest legal half-period in source clocks
//   clamp_half : raises a requested half-period to at least HALF_MIN
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HIGH    = 2'd1,
    ST_STRETCH = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam int unsigned HALF_MIN = 2;

  // Half-periods of 0 or 1 would collapse a phase, so they become HALF_MIN.
  function automatic int unsigned clamp_half(input int unsigned val);
    return (val < HALF_MIN) ? HALF_MIN : val;
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Request/status bundle between the 6502 glue logic and cpu_clk_ctrl.
//   master : drives divisor load, wait-state request, HALT and STEP
//   slave  : the controller; returns PHI0, edge strobes and HALTED
interface cpu_clk_ctrl_if #(
  parameter int unsigned HALF_W = 8,
  parameter int unsigned WAIT_W = 4
) ();

  logic              DIV_LOAD;
  logic [HALF_W-1:0] DIV_VAL;
  logic              WAIT_REQ;
  logic [WAIT_W-1:0] WAIT_N;
  logic              HALT;
  logic              STEP;
  logic              PHI0;
  logic              PHI_RISE;
  logic              PHI_FALL;
  logic              HALTED;

  modport master (
    output DIV_LOAD, DIV_VAL, WAIT_REQ, WAIT_N, HALT, STEP,
    input  PHI0, PHI_RISE, PHI_FALL, HALTED
  );

  modport slave (
    input  DIV_LOAD, DIV_VAL, WAIT_REQ, WAIT_N, HALT, STEP,
    output PHI0, PHI_RISE, PHI_FALL, HALTED
  );

endinterface

// File: rtl/edge_pulse.sv
// Rising-edge detector: pulse_c_o is high for the clock where sig_i is 1
// and was 0 on the previous clock.
//   clk, rst_n : clock, async active-low reset
//   sig_i      : synchronous level input
//   pulse_c_o  : combinational one-clock rising-edge pulse
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_c_o
);

  logic prev_q;

  // Previous value of sig_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign pulse_c_o = sig_i & ~prev_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// PHI0 generator and sequencer for the 6502 core, run from CLK_SRC.
// Programmable half-period, wait-state stretch of the high phase,
// halt/single-step parking in the low phase, and registered edge strobes.
//   CLK_SRC, RESET_N : source clock, async active-low reset
//   bus (slave)      : DIV_LOAD/DIV_VAL, WAIT_REQ/WAIT_N, HALT, STEP in;
//                      PHI0, PHI_RISE, PHI_FALL, HALTED out (all registered)
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int unsigned DEFAULT_HALF = 4,
  parameter int unsigned HALF_W       = 8,
  parameter int unsigned WAIT_W       = 4
) (
  input  logic           CLK_SRC,
  input  logic           RESET_N,
  cpu_clk_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   cnt_q, cnt_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [HALF_W-1:0]   pending_half_q, pending_half_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                step_pending_q, step_pending_d;
  logic                phi0_q, phi0_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                halted_q, halted_d;

  logic                step_rise_c;
  logic                phase_end_c;
  logic                step_eff_c;
  logic                go_high_c;
  logic                go_low_c;

  edge_pulse u_step_edge (
    .clk       (CLK_SRC),
    .rst_n     (RESET_N),
    .sig_i     (bus.STEP),
    .pulse_c_o (step_rise_c)
  );

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    half_d         = half_q;
    wcnt_d         = wcnt_q;
    rise_d         = 1'b0;
    fall_d         = 1'b0;
    go_high_c      = 1'b0;
    go_low_c       = 1'b0;
    phase_end_c    = (cnt_q == (half_q - HALF_W'(1)));
    // A step edge landing on the low end-of-phase still counts.
    step_eff_c     = step_pending_q | (step_rise_c & bus.HALT);
    pending_half_d = pending_half_q;
    step_pending_d = step_pending_q;

    case (state_q)
      ST_LOW: begin
        if (phase_end_c) begin
          if (bus.HALT && !step_eff_c) begin
            state_d = ST_HALT;
          end else begin
            go_high_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + HALF_W'(1);
        end
      end
      ST_HALT: begin
        if (!bus.HALT || step_pending_q) begin
          go_high_c = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_end_c) begin
          if (bus.WAIT_REQ && (bus.WAIT_N != '0)) begin
            state_d = ST_STRETCH;
            wcnt_d  = bus.WAIT_N - WAIT_W'(1);
          end else begin
            go_low_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + HALF_W'(1);
        end
      end
      ST_STRETCH: begin
        if (wcnt_q == '0) begin
          go_low_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase

    if (go_high_c) begin
      state_d = ST_HIGH;
      cnt_d   = '0;
      rise_d  = 1'b1;
    end

    // New divisor only takes effect at a phase boundary into LOW.
    if (go_low_c) begin
      state_d = ST_LOW;
      cnt_d   = '0;
      fall_d  = 1'b1;
      half_d  = pending_half_q;
    end

    if (bus.DIV_LOAD) begin
      pending_half_d = HALF_W'(clamp_half(32'(bus.DIV_VAL)));
    end

    // Leaving toward HIGH consumes any step; dropping HALT discards it.
    if (go_high_c || !bus.HALT) begin
      step_pending_d = 1'b0;
    end else if (step_rise_c) begin
      step_pending_d = 1'b1;
    end

    phi0_d   = (state_d == ST_HIGH) || (state_d == ST_STRETCH);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers.
  always_ff @(posedge CLK_SRC or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_LOW;
      cnt_q          <= '0;
      half_q         <= HALF_W'(DEFAULT_HALF);
      pending_half_q <= HALF_W'(DEFAULT_HALF);
      wcnt_q         <= '0;
      step_pending_q <= 1'b0;
      phi0_q         <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      half_q         <= half_d;
      pending_half_q <= pending_half_d;
      wcnt_q         <= wcnt_d;
      step_pending_q <= step_pending_d;
      phi0_q         <= phi0_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      halted_q       <= halted_d;
    end
  end

  assign bus.PHI0     = phi0_q;
  assign bus.PHI_RISE = rise_q;
  assign bus.PHI_FALL = fall_q;
  assign bus.HALTED   = halted_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized bench for cpu_clk_ctrl against a phase-duration reference model.
module tb_cpu_clk_ctrl;

  localparam int unsigned HALF_W       = 8;
  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned DEFAULT_HALF = 4;
  localparam int          N_CYCLES     = 6000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #10 clk = ~clk;

  cpu_clk_ctrl_if #(.HALF_W(HALF_W), .WAIT_W(WAIT_W)) bus ();

  cpu_clk_ctrl #(
    .DEFAULT_HALF (DEFAULT_HALF),
    .HALF_W       (HALF_W),
    .WAIT_W       (WAIT_W)
  ) dut (
    .CLK_SRC (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase level, remaining clocks in the current phase.
  bit m_phi, m_halted, m_rise, m_fall, m_ext, m_step, m_prev;
  int m_rem, m_half, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phi = 0; m_halted = 0; m_rise = 0; m_fall = 0; m_ext = 0;
    m_step = 0; m_prev = 0;
    m_half = DEFAULT_HALF; m_pend = DEFAULT_HALF; m_rem = DEFAULT_HALF;
  endtask

  task automatic start_high();
    m_phi = 1; m_halted = 0; m_rem = m_half; m_rise = 1;
  endtask

  // One source clock of the model, using the inputs present at the edge.
  task automatic model_edge();
    bit se, consumed;
    se = bus.STEP && !m_prev;
    m_prev = bus.STEP;
    consumed = 0; m_rise = 0; m_fall = 0;
    if (m_halted) begin
      if (!bus.HALT || m_step) begin start_high(); consumed = 1; end
    end else if (!m_phi) begin
      if (m_rem == 1) begin
        if (bus.HALT && !(m_step || se)) m_halted = 1;
        else begin start_high(); consumed = 1; end
      end else m_rem--;
    end else begin
      if (m_rem == 1) begin
        if (!m_ext && bus.WAIT_REQ && bus.WAIT_N != 0) begin
          m_ext = 1; m_rem = int'(bus.WAIT_N);
        end else begin
          m_phi = 0; m_ext = 0; m_half = m_pend; m_rem = m_half; m_fall = 1;
        end
      end else m_rem--;
    end
    if (consumed || !bus.HALT) m_step = 0;
    else if (se) m_step = 1;
    if (bus.DIV_LOAD) m_pend = (int'(bus.DIV_VAL) < 2) ? 2 : int'(bus.DIV_VAL);
  endtask

  task automatic check_outputs(input int cyc);
    check($sformatf("phi0@%0d", cyc),   32'(bus.PHI0),     32'(m_phi));
    check($sformatf("rise@%0d", cyc),   32'(bus.PHI_RISE), 32'(m_rise));
    check($sformatf("fall@%0d", cyc),   32'(bus.PHI_FALL), 32'(m_fall));
    check($sformatf("halted@%0d", cyc), 32'(bus.HALTED),   32'(m_halted));
  endtask

  task automatic drive_idle();
    bus.DIV_LOAD = 0; bus.DIV_VAL = '0; bus.WAIT_REQ = 0; bus.WAIT_N = '0;
    bus.HALT = 0; bus.STEP = 0;
  endtask

  task automatic drive_random();
    bus.DIV_LOAD = ($urandom_range(0, 39) == 0);
    bus.DIV_VAL  = HALF_W'($urandom_range(0, 12));
    bus.WAIT_REQ = ($urandom_range(0, 2) == 0);
    bus.WAIT_N   = WAIT_W'($urandom_range(0, 5));
    if ($urandom_range(0, 59) == 0) bus.HALT = ~bus.HALT;
    if ($urandom_range(0, 9) == 0)  bus.STEP = ~bus.STEP;
  endtask

  initial begin
    bit stretch_reset_done;
    int rst_hold;
    stretch_reset_done = 0;
    rst_hold = 0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs(-1);
    rst_n = 1'b1;

    for (int k = 1; k <= N_CYCLES; k++) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_outputs(k);

      // Default divisor, no requests: low 0-3, high 4-7, period 8.
      if (k <= 40) begin
        check($sformatf("idle_phi@%0d", k),  32'(bus.PHI0),     32'((k / 4) % 2));
        check($sformatf("idle_rise@%0d", k), 32'(bus.PHI_RISE), 32'(k % 8 == 4));
        check($sformatf("idle_fall@%0d", k), 32'(bus.PHI_FALL), 32'(k % 8 == 0));
      end

      if (!rst_n) begin
        if (rst_hold > 0) rst_hold--;
        else rst_n = 1'b1;
      end

      if (k < 40) drive_idle();
      else drive_random();

      // Reset in the middle of a stretch, then occasionally at random.
      if (rst_n && k > 40 &&
          ((!stretch_reset_done && m_ext && k > 2000) || $urandom_range(0, 799) == 0)) begin
        if (m_ext) stretch_reset_done = 1;
        rst_n = 1'b0;
        rst_hold = 0;
        #1;
        model_reset();
        check($sformatf("async_phi0@%0d", k),   32'(bus.PHI0),   32'(0));
        check($sformatf("async_halted@%0d", k), 32'(bus.HALTED), 32'(0));
      end
    end

    check("stretch_reset_seen", 32'(stretch_reset_done), 32'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Programmable PHI0 generator and sequencer for the 6502 core, clocked from the 50 MHz board source.
- Produces PHI0 with a runtime-selectable half-period.
- Stretches the high phase with wait states for slow peripherals flagged by the address decoder.
- Supports halt and single-step, stopping in the low phase.
- Emits one-source-clock edge strobes for glue logic in the CLK_SRC domain.

Parameters:
DEFAULT_HALF, 4, source clocks per PHI0 phase after reset (4 gives 50/8 = 6.25 MHz)
HALF_W, 8, width of the half-period value and the phase counter
WAIT_W, 4, width of the wait-state count

Ports:
CLK_SRC  in  1  50 MHz source clock
RESET_N  in  1  asynchronous active-low reset
DIV_LOAD  in  1  one-clock strobe: capture DIV_VAL as the pending half-period
DIV_VAL  in  HALF_W  requested half-period in source clocks; values 0 and 1 are clamped to 2
WAIT_REQ  in  1  decoder flags a slow access; sampled only on the last clock of the HIGH phase
WAIT_N  in  WAIT_W  wait states to add; sampled with WAIT_REQ
HALT  in  1  level; request that the CPU stop in the low phase
STEP  in  1  synchronous level; each rising edge releases one full PHI0 cycle while halted
PHI0  out  1  CPU clock, registered
PHI_RISE  out  1  high for the one source clock on which PHI0 first reads 1
PHI_FALL  out  1  high for the one source clock on which PHI0 first reads 0
HALTED  out  1  high while in the HALT state

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state LOW, cnt=0, half=DEFAULT_HALF, pending_half=DEFAULT_HALF.
  - step_pending=0, wcnt=0.
  - Outputs: PHI0=0, PHI_RISE=0, PHI_FALL=0, HALTED=0.
  - Reset asserted mid-phase or mid-stretch aborts immediately to these values.
- All outputs are registered. PHI0=1 exactly in HIGH and STRETCH.
- LOW:
  - cnt counts 0..half-1.
  - At cnt==half-1: if HALT=1 and step_pending=0, go to HALT; otherwise go to HIGH with cnt=0, assert PHI_RISE, and clear step_pending.
- HALT:
  - PHI0=0, HALTED=1.
  - Exit to HIGH (PHI_RISE, cnt=0) when HALT=0 or step_pending=1; a step exit clears step_pending.
  - HALTED deasserts together with PHI0 rising.
- HIGH:
  - cnt counts 0..half-1.
  - At cnt==half-1: if WAIT_REQ=1 and WAIT_N!=0, go to STRETCH with wcnt=WAIT_N-1.
  - Otherwise go to LOW with cnt=0, assert PHI_FALL, and load half from pending_half.
- STRETCH:
  - PHI0 stays 1; wcnt decrements each clock.
  - At wcnt==0, go to LOW (PHI_FALL, half updated).
  - WAIT_REQ is not re-sampled; the high phase lasts exactly half+WAIT_N clocks.
- Divisor change:
  - DIV_LOAD updates pending_half (after clamping) at any time; a later DIV_LOAD in the same cycle window overwrites it.
  - Applied only on entry to LOW, so no phase is ever truncated.
  - The first low phase after the change uses the new value.
- Step:
  - A rising edge on STEP (registered previous value) sets step_pending only if HALT=1; edges while pending are ignored.
  - step_pending is cleared when HALT=0.
  - A STEP edge in the same clock as a LOW end-of-phase is counted; the CPU does not halt.
  - Result: exactly one PHI0 cycle per step, then re-entry to HALT at the following LOW end.
- Period:
  - Normal period is 2*half source clocks with 50% duty.
  - Halted duration adds to the low phase only.
- Strobes: PHI_RISE and PHI_FALL are never both high and are never high in consecutive clocks.

Decomposition:
- Package cpu_clk_pkg holds:
  - the state enum (LOW, HIGH, STRETCH, HALT);
  - HALF_MIN=2;
  - the clamp function for DIV_VAL.
- Sub-module edge_pulse handles the STEP rising-edge detect: one register and one output pulse, reset to 0.
- The counter and FSM stay in cpu_clk_ctrl.

Test Plan:
- Reset release, defaults, no requests:
  - PHI0 low for clocks 0-3, high for 4-7, period 8.
  - PHI_RISE on the clocks where PHI0 first reads 1 (4, 12, …); PHI_FALL on 8, 16, ….
- DIV_LOAD with DIV_VAL=10 during a HIGH phase:
  - The current high phase still lasts 4 clocks.
  - The next low phase is 10 clocks; the period is 20 from then on.
  - DIV_VAL=0 gives a period of 4.
- WAIT_REQ=1, WAIT_N=3 held through the end of HIGH (half=4): the high phase lasts 7 clocks and the low phase stays 4.
  - With WAIT_N=0 the high phase stays 4.
  - WAIT_REQ dropped during STRETCH still gives 7.
- HALT=1 raised mid-cycle:
  - After the next complete low phase, PHI0 stays 0 and HALTED=1 indefinitely.
  - Three STEP edges produce exactly three PHI_RISE/PHI_FALL pairs, each with a 4-clock high phase.
  - HALT=0 resumes free-running operation.
- RESET_N pulsed low for 1 clock during STRETCH:
  - PHI0=0 asynchronously and HALTED=0.
  - Restarts with DEFAULT_HALF; pending divisor and step state are cleared.
